ste_sound_shifter: RTL and testbench

- Consumer end of the STE DMA-sound path.
- Accepts 16-bit sound words strobed in by the MCU sound-DMA load cycle and buffers them in a small FIFO.
- Drives the sound-request line back to the MCU.
- Unpacks the words into signed 8-bit left/right samples at the programmed sample rate, for the DAC/mixer.

---
 rtl/ste_sound_pkg.sv | 8 +
 rtl/ste_sound_shifter_fifo.sv | 38 +++
 rtl/ste_sound_shifter.sv | 66 ++++++
 tb/tb_ste_sound_shifter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ste_sound_pkg.sv
// ste_sound_pkg: shared sample-rate encodings and prescaler terminal-count helper for the STE sound path.
package ste_sound_pkg;
   typedef enum logic [1:0] {SRATE_DIV8, SRATE_DIV4, SRATE_DIV2, SRATE_DIV1} srate_e;
   localparam int DEF_BASE_DIV = 640;
   function automatic logic [15:0] rate_limit(input srate_e srate, input int unsigned base = DEF_BASE_DIV);
      return 16'((base << 2'(SRATE_DIV1 - srate)) - 1);
   endfunction
endpackage

// File: rtl/ste_sound_shifter_fifo.sv
// sound_word_fifo: synchronous sound-word FIFO; a pop frees the slot a same-cycle push needs when full.
module sound_word_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk32,
   input  logic                     porb,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [15:0]              din,
   output logic [15:0]              dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [15:0] mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic do_pop, do_push;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign dout = mem[rd];
   always_ff @(posedge clk32)
      if (do_push) mem[wr] <= din;
   always_ff @(posedge clk32) begin
      if (!porb || flush) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr + AW'(1);
         if (do_pop) rd <= rd + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/ste_sound_shifter.sv
// ste_sound_shifter: buffers DMA sound words and unpacks them into signed 8-bit L/R samples at the programmed rate.
module ste_sound_shifter
   import ste_sound_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_DIV = DEF_BASE_DIV
) (
   input  logic        clk32,
   input  logic        porb,
   input  logic        sload,
   input  logic [15:0] sdata,
   input  logic        sndon,
   input  logic [1:0]  srate,
   input  logic        mono,
   output logic        sreq,
   output logic [7:0]  left,
   output logic [7:0]  right,
   output logic        stick,
   output logic        underrun,
   output logic        overrun
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [15:0] pcnt, head;
   logic [CW-1:0] count;
   logic tick, pop, rise, full, empty, bsel, sndon_q;
   // live compare so an srate change lands on the next wrap without resetting the counter
   assign tick = sndon && pcnt >= rate_limit(srate_e'(srate), BASE_DIV);
   assign pop = tick && !empty && (!mono || bsel);
   assign rise = sndon && !sndon_q;
   sound_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk32(clk32), .porb(porb), .flush(!sndon), .push(sload), .pop(pop),
      .din(sdata), .dout(head), .full(full), .empty(empty), .count(count)
   );
   always_ff @(posedge clk32) begin
      if (!porb) begin
         pcnt <= '0;
         bsel <= 1'b0;
         sndon_q <= 1'b0;
         sreq <= 1'b0;
         left <= '0;
         right <= '0;
         stick <= 1'b0;
         underrun <= 1'b0;
         overrun <= 1'b0;
      end else begin
         sndon_q <= sndon;
         underrun <= (underrun && !rise) || (tick && empty);
         overrun <= (overrun && !rise) || (sndon && sload && full && !pop);
         sreq <= sndon && count <= CW'(FIFO_DEPTH - 2);
         stick <= tick && !empty;
         if (!sndon) begin
            pcnt <= '0;
            bsel <= 1'b0;
            left <= '0;
            right <= '0;
         end else begin
            pcnt <= tick ? '0 : pcnt + 16'd1;
            if (tick && !empty) begin
               left <= (mono && bsel) ? head[7:0] : head[15:8];
               right <= (mono && !bsel) ? head[15:8] : head[7:0];
               bsel <= mono && !bsel;
            end
         end
      end
   end
endmodule

// File: tb/tb_ste_sound_shifter.sv
// tb_ste_sound_shifter: directed self-checking bench for ste_sound_shifter.
module tb_ste_sound_shifter;
   logic clk32 = 1'b0, porb, sload, sndon, mono;
   logic [15:0] sdata;
   logic [1:0] srate;
   logic sreq, stick, underrun, overrun;
   logic [7:0] left, right;
   int checks = 0, errors = 0;

   ste_sound_shifter dut (
      .clk32(clk32), .porb(porb), .sload(sload), .sdata(sdata), .sndon(sndon),
      .srate(srate), .mono(mono), .sreq(sreq), .left(left), .right(right),
      .stick(stick), .underrun(underrun), .overrun(overrun)
   );

   always #5 clk32 = ~clk32;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk32);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      porb = 1'b0; sload = 1'b0; sdata = '0; sndon = 1'b0; srate = 2'b11; mono = 1'b0;
      cyc(2);
      chk("rst_sreq", sreq, 0);
      chk("rst_lr", {left, right}, 0);
      chk("rst_stick", stick, 0);
      chk("rst_flags", {underrun, overrun}, 0);
      porb = 1'b1;
      // 1: empty playback underruns on the 640th cycle
      sndon = 1'b1;
      cyc(1);
      chk("t1_sreq", sreq, 1);
      cyc(638);
      chk("t1_pre_underrun", underrun, 0);
      cyc(1);
      chk("t1_underrun", underrun, 1);
      chk("t1_stick", stick, 0);
      chk("t1_lr", {left, right}, 0);
      // 2: stereo unpack
      sload = 1'b1; sdata = 16'h7F80;
      cyc(1);
      sdata = 16'h0102;
      cyc(1);
      sload = 1'b0;
      cyc(637);
      chk("t2_pre_stick", stick, 0);
      cyc(1);
      chk("t2_tick1_lr", {left, right}, 16'h7F80);
      chk("t2_tick1_stick", stick, 1);
      cyc(1);
      chk("t2_stick_pulse", stick, 0);
      cyc(638);
      chk("t2_hold", {left, right}, 16'h7F80);
      cyc(1);
      chk("t2_tick2_lr", {left, right}, 16'h0102);
      chk("t2_tick2_stick", stick, 1);
      // 3: mono at half rate
      srate = 2'b10; mono = 1'b1;
      sload = 1'b1; sdata = 16'h1234;
      cyc(1);
      sload = 1'b0;
      cyc(1278);
      chk("t3_pre_stick", stick, 0);
      cyc(1);
      chk("t3_hi_lr", {left, right}, 16'h1212);
      chk("t3_hi_stick", stick, 1);
      cyc(1280);
      chk("t3_lo_lr", {left, right}, 16'h3434);
      chk("t3_lo_stick", stick, 1);
      cyc(1280);
      chk("t3_empty_stick", stick, 0);
      chk("t3_empty_lr", {left, right}, 16'h3434);
      // sndon low one cycle: datapath cleared, sticky flags held until rise
      mono = 1'b0; srate = 2'b11; sndon = 1'b0;
      cyc(1);
      chk("off_lr", {left, right}, 0);
      chk("off_sreq", sreq, 0);
      chk("off_underrun_held", underrun, 1);
      sndon = 1'b1;
      cyc(1);
      chk("on_underrun_clr", underrun, 0);
      chk("on_sreq", sreq, 1);
      // 4/5: fill, coincident push on tick while full, then overrun
      sload = 1'b1;
      sdata = 16'hA1A2; cyc(1);
      sdata = 16'hB1B2; cyc(1);
      sdata = 16'hC1C2; cyc(1);
      sdata = 16'hD1D2; cyc(1);
      sload = 1'b0;
      chk("t4_sreq_low", sreq, 0);
      cyc(634);
      chk("t4_no_overrun", overrun, 0);
      sload = 1'b1; sdata = 16'h5566;
      cyc(1);
      chk("t5_lr", {left, right}, 16'hA1A2);
      chk("t5_overrun", overrun, 0);
      sdata = 16'hEEEE;
      cyc(1);
      sload = 1'b0;
      chk("t4_overrun", overrun, 1);
      chk("t5_sreq_full", sreq, 0);
      cyc(638);
      cyc(1);
      chk("t4_drain_b", {left, right}, 16'hB1B2);
      cyc(640);
      chk("t4_drain_c", {left, right}, 16'hC1C2);
      cyc(640);
      chk("t4_drain_d", {left, right}, 16'hD1D2);
      cyc(640);
      chk("t5_drain_new", {left, right}, 16'h5566);
      cyc(640);
      chk("t4_dropped_stick", stick, 0);
      chk("t4_dropped_lr", {left, right}, 16'h5566);
      chk("t4_underrun", underrun, 1);
      // 6: flush with words queued
      sload = 1'b1;
      sdata = 16'h1111; cyc(1);
      sdata = 16'h2222; cyc(1);
      sload = 1'b0; sndon = 1'b0;
      cyc(1);
      chk("t6_lr", {left, right}, 0);
      chk("t6_flags_held", {underrun, overrun}, 2'b11);
      sndon = 1'b1;
      cyc(1);
      chk("t6_sreq", sreq, 1);
      chk("t6_flags_clr", {underrun, overrun}, 0);
      cyc(638);
      cyc(1);
      chk("t6_empty_underrun", underrun, 1);
      chk("t6_empty_stick", stick, 0);
      chk("t6_empty_lr", {left, right}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
